// File: rtl/board_clocked_if.sv
// board_clocked_if: ball-protocol bundle between the board (master) and the piece network/harness (slave)
interface board_clocked_if #(
  parameter int TRAY_BITS = 32
);
  logic                 start;
  logic                 blue_trigger;
  logic                 red_trigger;
  logic                 halt;
  logic                 blue_ball;
  logic                 red_ball;
  logic                 current_color;
  logic                 in_flight;
  logic                 stopped;
  logic                 no_balls;
  logic                 proto_error;
  logic [TRAY_BITS-1:0] tray;
  logic [5:0]           tray_amount;
  logic [4:0]           blue_left;
  logic [4:0]           red_left;
  modport master (
    input  start, blue_trigger, red_trigger, halt,
    output blue_ball, red_ball, current_color, in_flight, stopped, no_balls,
           proto_error, tray, tray_amount, blue_left, red_left
  );
  modport slave (
    output start, blue_trigger, red_trigger, halt,
    input  blue_ball, red_ball, current_color, in_flight, stopped, no_balls,
           proto_error, tray, tray_amount, blue_left, red_left
  );
endinterface

// File: rtl/board_clocked.sv
// board_clocked: clocked Turing Tumble board; ports clk, rst (async high), bus (board_clocked_if.master: start/triggers/halt in, ball pulses, status, tray and reservoirs out)
module board_clocked #(
  parameter int AMOUNT_BLUE = 10,
  parameter int AMOUNT_RED  = 10,
  parameter int TRAY_BITS   = 32
) (
  input logic             clk,
  input logic             rst,
  board_clocked_if.master bus
);
  typedef enum logic [1:0] {IDLE, FLIGHT, DONE} state_t;
  state_t state;
  logic any_trig, both_trig, tray_full;
  logic [4:0] req_left;
  logic [TRAY_BITS-1:0] tray_next;
  always_comb begin
    any_trig  = bus.blue_trigger | bus.red_trigger;
    both_trig = bus.blue_trigger & bus.red_trigger;
    tray_full = bus.tray_amount == 6'(TRAY_BITS);
    req_left  = bus.red_trigger ? bus.red_left : bus.blue_left;
    tray_next = bus.tray | (TRAY_BITS'(bus.current_color) << bus.tray_amount);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus.blue_ball     <= 1'b0;
      bus.red_ball      <= 1'b0;
      bus.current_color <= 1'b0;
      bus.in_flight     <= 1'b0;
      bus.stopped       <= 1'b0;
      bus.no_balls      <= 1'b0;
      bus.proto_error   <= 1'b0;
      bus.tray          <= '0;
      bus.tray_amount   <= '0;
      bus.blue_left     <= 5'(AMOUNT_BLUE);
      bus.red_left      <= 5'(AMOUNT_RED);
    end else begin
      bus.blue_ball <= 1'b0;
      bus.red_ball  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_trig | bus.halt) bus.proto_error <= 1'b1;
          if (bus.start) begin
            if (bus.blue_left != 5'd0) begin
              bus.blue_ball     <= 1'b1;
              bus.blue_left     <= bus.blue_left - 5'd1;
              bus.current_color <= 1'b0;
              bus.in_flight     <= 1'b1;
              state             <= FLIGHT;
            end else begin
              bus.no_balls <= 1'b1;
              bus.stopped  <= 1'b1;
              state        <= DONE;
            end
          end
        end
        FLIGHT: begin
          if (bus.start) bus.proto_error <= 1'b1;
          if (bus.halt) begin
            bus.in_flight <= 1'b0;
            bus.stopped   <= 1'b1;
            state         <= DONE;
          end else if (any_trig) begin
            // a full tray drops the arriving ball but the run continues
            if (tray_full) bus.proto_error <= 1'b1;
            else begin
              bus.tray        <= tray_next;
              bus.tray_amount <= bus.tray_amount + 6'd1;
            end
            if (both_trig) begin
              bus.proto_error <= 1'b1;
              bus.in_flight   <= 1'b0;
              bus.stopped     <= 1'b1;
              state           <= DONE;
            end else if (req_left != 5'd0) begin
              bus.current_color <= bus.red_trigger;
              if (bus.red_trigger) begin
                bus.red_ball <= 1'b1;
                bus.red_left <= bus.red_left - 5'd1;
              end else begin
                bus.blue_ball <= 1'b1;
                bus.blue_left <= bus.blue_left - 5'd1;
              end
            end else begin
              bus.no_balls  <= 1'b1;
              bus.in_flight <= 1'b0;
              bus.stopped   <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: if (bus.start | any_trig) bus.proto_error <= 1'b1;
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_clocked.sv
// tb_board_clocked: scoreboard bench for board_clocked (3/2 reservoir with 3-ball tray, and 1/0 reservoir)
module tb_board_clocked;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  always #5 clk = ~clk;
  board_clocked_if #(.TRAY_BITS(3)) a_if ();
  board_clocked_if #(.TRAY_BITS(32)) b_if ();
  board_clocked #(.AMOUNT_BLUE(3), .AMOUNT_RED(2), .TRAY_BITS(3)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  board_clocked #(.AMOUNT_BLUE(1), .AMOUNT_RED(0), .TRAY_BITS(32)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ball pulses are scored against the queue of releases the stimulus predicted; {red_ball, blue_ball}
  always @(posedge clk) begin
    #1;
    if (a_if.blue_ball | a_if.red_ball) begin
      if (qa.size() == 0) check("a_unexpected_ball", {30'd0, a_if.red_ball, a_if.blue_ball}, 32'd0);
      else check("a_ball", {30'd0, a_if.red_ball, a_if.blue_ball}, {30'd0, qa.pop_front()});
    end
    if (b_if.blue_ball | b_if.red_ball) begin
      if (qb.size() == 0) check("b_unexpected_ball", {30'd0, b_if.red_ball, b_if.blue_ball}, 32'd0);
      else check("b_ball", {30'd0, b_if.red_ball, b_if.blue_ball}, {30'd0, qb.pop_front()});
    end
  end
  task automatic cyc_a(input logic s, input logic bt, input logic rt, input logic h);
    {a_if.start, a_if.blue_trigger, a_if.red_trigger, a_if.halt} = {s, bt, rt, h};
    @(posedge clk);
    #1;
    {a_if.start, a_if.blue_trigger, a_if.red_trigger, a_if.halt} = 4'b0;
  endtask
  task automatic cyc_b(input logic s, input logic bt, input logic rt, input logic h);
    {b_if.start, b_if.blue_trigger, b_if.red_trigger, b_if.halt} = {s, bt, rt, h};
    @(posedge clk);
    #1;
    {b_if.start, b_if.blue_trigger, b_if.red_trigger, b_if.halt} = 4'b0;
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #2;
  endtask
  initial begin
    {a_if.start, a_if.blue_trigger, a_if.red_trigger, a_if.halt} = 4'b0;
    {b_if.start, b_if.blue_trigger, b_if.red_trigger, b_if.halt} = 4'b0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    check("a_reset_blue", a_if.blue_left, 3);
    check("a_reset_red", a_if.red_left, 2);
    check("a_reset_tray", {a_if.tray_amount, 23'd0, a_if.tray}, 0);
    check("a_reset_flags", {a_if.in_flight, a_if.stopped, a_if.no_balls, a_if.proto_error, a_if.current_color}, 0);
    check("b_reset_left", {b_if.blue_left, b_if.red_left}, {5'd1, 5'd0});
    // exhaustion on the 1/0 board
    qb.push_back(2'b01);
    cyc_b(1, 0, 0, 0);
    check("b_start_flight", {b_if.in_flight, b_if.blue_left}, {1'b1, 5'd0});
    cyc_b(0, 0, 1, 0);
    check("b_exh_tray", {b_if.tray_amount, b_if.tray[0]}, {6'd1, 1'b0});
    check("b_exh_flags", {b_if.no_balls, b_if.stopped, b_if.in_flight, b_if.proto_error}, 4'b1100);
    cyc_b(0, 0, 0, 0);
    // alternating run on the 3/2 board, ending with a full tray
    qa.push_back(2'b01);
    cyc_a(1, 0, 0, 0);
    check("a_start", {a_if.blue_left, a_if.in_flight, a_if.current_color}, {5'd2, 1'b1, 1'b0});
    cyc_a(0, 0, 0, 0);
    check("a_start_pulse_once", {a_if.blue_ball, a_if.red_ball}, 0);
    qa.push_back(2'b10);
    cyc_a(0, 0, 1, 0);
    check("a_alt1", {a_if.tray_amount, a_if.red_left, a_if.current_color}, {6'd1, 5'd1, 1'b1});
    qa.push_back(2'b01);
    cyc_a(0, 1, 0, 0);
    check("a_alt2", {a_if.tray_amount, a_if.blue_left, a_if.current_color}, {6'd2, 5'd1, 1'b0});
    qa.push_back(2'b10);
    cyc_a(0, 0, 1, 0);
    check("a_alt3_tray", {a_if.tray_amount, a_if.tray}, {6'd3, 3'b010});
    check("a_alt3_left", {a_if.red_left, a_if.blue_left, a_if.proto_error}, {5'd0, 5'd1, 1'b0});
    qa.push_back(2'b01);
    cyc_a(0, 1, 0, 0);
    check("a_full_tray", {a_if.tray_amount, a_if.tray}, {6'd3, 3'b010});
    check("a_full_flags", {a_if.proto_error, a_if.in_flight, a_if.blue_left}, {1'b1, 1'b1, 5'd0});
    cyc_a(0, 0, 1, 0);
    check("a_red_empty", {a_if.no_balls, a_if.stopped, a_if.in_flight, a_if.tray_amount}, {3'b110, 6'd3});
    cyc_a(1, 0, 0, 0);
    check("a_done_sticks", {a_if.stopped, a_if.in_flight, a_if.blue_left}, {2'b10, 5'd0});
    // violations: trigger in IDLE, then both triggers in FLIGHT
    pulse_rst();
    check("a_rst_reload", {a_if.blue_left, a_if.red_left, a_if.tray_amount}, {5'd3, 5'd2, 6'd0});
    check("a_rst_flags", {a_if.stopped, a_if.no_balls, a_if.proto_error}, 0);
    cyc_a(0, 0, 1, 0);
    check("a_idle_trig", {a_if.proto_error, a_if.in_flight, a_if.stopped, a_if.tray_amount}, {3'b100, 6'd0});
    qa.push_back(2'b01);
    cyc_a(1, 0, 0, 0);
    check("a_idle_then_start", {a_if.in_flight, a_if.blue_left}, {1'b1, 5'd2});
    cyc_a(0, 1, 1, 0);
    check("a_both_trig", {a_if.proto_error, a_if.stopped, a_if.in_flight, a_if.tray_amount}, {3'b110, 6'd1});
    check("a_both_left", {a_if.blue_left, a_if.red_left}, {5'd2, 5'd2});
    // interceptor: halt beats a simultaneous trigger
    pulse_rst();
    qa.push_back(2'b01);
    cyc_a(1, 0, 0, 0);
    cyc_a(0, 1, 0, 1);
    check("a_halt", {a_if.stopped, a_if.in_flight, a_if.no_balls, a_if.tray_amount}, {3'b100, 6'd0});
    check("a_halt_left", a_if.blue_left, 2);
    repeat (3) cyc_a(0, 1, 0, 0);
    // async reset between edges while a ball is in flight
    pulse_rst();
    qa.push_back(2'b01);
    cyc_a(1, 0, 0, 0);
    check("a_pre_async", a_if.in_flight, 1);
    #2 rst = 1'b1;
    #1;
    check("a_async_clear", {a_if.in_flight, a_if.blue_left, a_if.red_left, a_if.tray_amount}, {1'b0, 5'd3, 5'd2, 6'd0});
    rst = 1'b0;
    @(posedge clk);
    #1;
    qa.push_back(2'b01);
    cyc_a(1, 0, 0, 0);
    check("a_restart", {a_if.in_flight, a_if.blue_left, a_if.current_color}, {1'b1, 5'd2, 1'b0});
    repeat (2) cyc_a(0, 0, 0, 0);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
